// File: rtl/program_launcher.sv
// Start-side driver for the program-counter launch protocol: pulses Start once per
// program, times each program until Done (or timeout) and reports its cycle count.
module program_launcher #(
    parameter int NUM_PROGS  = 3,
    parameter int START_HOLD = 4,
    parameter int TIMEOUT    = 4096,
    parameter int CW         = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Go,
    input  logic          Done,
    output logic          Start,
    output logic [1:0]    ProgNum,
    output logic          Busy,
    output logic [CW-1:0] CycleCount,
    output logic          CycleValid,
    output logic          TimedOut,
    output logic          AllDone
);

    localparam int            HW        = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [1:0]    LAST_PROG = 2'(NUM_PROGS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ASSERT  = 3'd1,
        S_RELEASE = 3'd2,
        S_WAIT    = 3'd3,
        S_REPORT  = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [HW-1:0] hold_r, hold_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          arm_r, arm_s;
    logic          start_r, start_s;
    logic [1:0]    prog_r, prog_s;
    logic          busy_r, busy_s;
    logic [CW-1:0] count_r, count_s;
    logic          valid_r, valid_s;
    logic          timed_out_r, timed_out_s;
    logic          all_done_r, all_done_s;

    // Next-state and next-output logic; outputs are computed one cycle ahead so they register cleanly.
    always_comb begin
        state_s     = state_r;
        hold_s      = hold_r;
        cnt_s       = cnt_r;
        arm_s       = arm_r;
        start_s     = 1'b0;
        prog_s      = prog_r;
        busy_s      = busy_r;
        count_s     = count_r;
        valid_s     = 1'b0;
        timed_out_s = timed_out_r;
        all_done_s  = all_done_r;

        case (state_r)
            S_IDLE, S_FINISH: begin
                if (Go) begin
                    state_s     = S_ASSERT;
                    start_s     = 1'b1;
                    busy_s      = 1'b1;
                    prog_s      = 2'd1;
                    timed_out_s = 1'b0;
                    all_done_s  = 1'b0;
                    hold_s      = {HW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            S_ASSERT: begin
                if (hold_r == HOLD_LAST) begin
                    state_s = S_RELEASE;
                    cnt_s   = {CW{1'b0}};
                    arm_s   = 1'b0;
                end else begin
                    hold_s  = hold_r + {{(HW-1){1'b0}}, 1'b1};
                    start_s = 1'b1;
                end
            end
            S_RELEASE: begin
                state_s = S_WAIT;
                cnt_s   = {{(CW-1){1'b0}}, 1'b1};
                arm_s   = 1'b0;
            end
            S_WAIT: begin
                // A Done left high by the previous program only counts after it has been seen low.
                arm_s = arm_r | ~Done;
                if (arm_r && Done) begin
                    state_s = S_REPORT;
                    valid_s = 1'b1;
                    count_s = cnt_r;
                end else if (cnt_r >= TIMEOUT_C) begin
                    state_s     = S_REPORT;
                    valid_s     = 1'b1;
                    count_s     = TIMEOUT_C;
                    timed_out_s = 1'b1;
                end else if (cnt_r == CNT_MAX) begin
                    cnt_s = cnt_r;
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_REPORT: begin
                if (prog_r < LAST_PROG) begin
                    state_s = S_ASSERT;
                    start_s = 1'b1;
                    prog_s  = prog_r + 2'd1;
                    hold_s  = {HW{1'b0}};
                end else begin
                    state_s    = S_FINISH;
                    busy_s     = 1'b0;
                    all_done_s = 1'b1;
                end
            end
            default: begin
                state_s    = S_IDLE;
                busy_s     = 1'b0;
                prog_s     = 2'd0;
                all_done_s = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= S_IDLE;
            hold_r      <= {HW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            arm_r       <= 1'b0;
            start_r     <= 1'b0;
            prog_r      <= 2'd0;
            busy_r      <= 1'b0;
            count_r     <= {CW{1'b0}};
            valid_r     <= 1'b0;
            timed_out_r <= 1'b0;
            all_done_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            hold_r      <= hold_s;
            cnt_r       <= cnt_s;
            arm_r       <= arm_s;
            start_r     <= start_s;
            prog_r      <= prog_s;
            busy_r      <= busy_s;
            count_r     <= count_s;
            valid_r     <= valid_s;
            timed_out_r <= timed_out_s;
            all_done_r  <= all_done_s;
        end
    end

    assign Start      = start_r;
    assign ProgNum    = prog_r;
    assign Busy       = busy_r;
    assign CycleCount = count_r;
    assign CycleValid = valid_r;
    assign TimedOut   = timed_out_r;
    assign AllDone    = all_done_r;

endmodule

// File: tb/tb_program_launcher.sv
// Directed bench for program_launcher: table of per-program Done timings with
// expected counts, plus hand-written Go-held and mid-launch reset sequences.
module tb_program_launcher;

    localparam int TO   = 32;
    localparam int HOLD = 4;
    localparam int CW   = 16;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Go;
    logic          Done;
    logic          Start;
    logic [1:0]    ProgNum;
    logic          Busy;
    logic [CW-1:0] CycleCount;
    logic          CycleValid;
    logic          TimedOut;
    logic          AllDone;

    program_launcher #(
        .NUM_PROGS (3),
        .START_HOLD(HOLD),
        .TIMEOUT   (TO),
        .CW        (CW)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Go        (Go),
        .Done      (Done),
        .Start     (Start),
        .ProgNum   (ProgNum),
        .Busy      (Busy),
        .CycleCount(CycleCount),
        .CycleValid(CycleValid),
        .TimedOut  (TimedOut),
        .AllDone   (AllDone)
    );

    always #5 Clk = ~Clk;

    // rise: cycles after the Start fall at which Done goes high (0 = never)
    // keep: Done from the previous program stays high until 5 cycles after the fall
    typedef struct {
        int rise;
        bit keep;
        int exp_cnt;
    } prog_t;

    prog_t progs[12];
    bit    seq_to[4];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_seq(input int s, input bit go_hold);
        int launches = 0;
        int valids   = 0;
        int rel      = -1;
        int hi       = 0;
        int cyc      = 0;
        int idx      = s * 3;
        bit prev     = 1'b0;
        Go = 1'b1;
        while (1) begin
            @(negedge Clk);
            cyc++;
            if (!go_hold) Go = 1'b0;
            if (cyc > 400) begin
                total++;
                bad++;
                $display("FAIL seq%0d_budget: AllDone not seen within %0d cycles", s, 400);
                return;
            end
            if (Start && !prev) begin
                launches++;
                idx = s * 3 + ((launches > 3) ? 2 : launches - 1);
                if (!progs[idx].keep) Done = 1'b0;
                check("busy_at_start", Busy, 1);
                hi = 0;
            end
            if (Start) hi++;
            if (!Start && prev) begin
                check("start_width", hi, HOLD);
                rel = 0;
            end
            if (CycleValid) begin
                valids++;
                check("prognum", ProgNum, launches);
                check("cyclecount", CycleCount, progs[idx].exp_cnt);
                check("busy_report", Busy, 1);
                rel = -1;
            end
            if (rel >= 0) begin
                if (progs[idx].keep && rel == 5) Done = 1'b0;
                if (progs[idx].rise != 0 && rel == progs[idx].rise) Done = 1'b1;
                rel++;
            end
            prev = Start;
            if (AllDone) break;
        end
        check("launches", launches, 3);
        check("valids", valids, 3);
        check("timedout", TimedOut, seq_to[s]);
        check("busy_finish", Busy, 0);
        check("prognum_finish", ProgNum, 3);
    endtask

    initial begin
        // normal 10/20/30
        progs[0]  = '{10, 1'b0, 10}; progs[1]  = '{20, 1'b0, 20}; progs[2]  = '{30, 1'b0, 30};
        seq_to[0] = 1'b0;
        // stale Done carried into program 2
        progs[3]  = '{10, 1'b0, 10}; progs[4]  = '{12, 1'b1, 12}; progs[5]  = '{7, 1'b0, 7};
        seq_to[1] = 1'b0;
        // timeout, Done exactly at TIMEOUT, Done one cycle too late
        progs[6]  = '{0, 1'b0, TO};  progs[7]  = '{TO, 1'b0, TO}; progs[8]  = '{TO + 1, 1'b0, TO};
        seq_to[2] = 1'b1;
        // Done exactly at TIMEOUT only: sticky flag must clear and stay clear
        progs[9]  = '{TO, 1'b0, TO}; progs[10] = '{5, 1'b0, 5};   progs[11] = '{2, 1'b0, 2};
        seq_to[3] = 1'b0;

        Reset_n = 1'b0;
        Go      = 1'b0;
        Done    = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_start", Start, 0);
        check("rst_prognum", ProgNum, 0);
        check("rst_busy", Busy, 0);
        check("rst_count", CycleCount, 0);
        check("rst_valid", CycleValid, 0);
        check("rst_timedout", TimedOut, 0);
        check("rst_alldone", AllDone, 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        for (int s = 0; s < 4; s++) begin
            run_seq(s, 1'b0);
        end

        // Go held through FINISH: exactly one new sequence per FINISH entry
        run_seq(0, 1'b1);
        @(negedge Clk);
        check("gohold_restart_start", Start, 1);
        check("gohold_restart_prognum", ProgNum, 1);
        check("gohold_restart_alldone", AllDone, 0);
        Go = 1'b0;

        // asynchronous reset in the middle of the Start pulse
        #2 Reset_n = 1'b0;
        #1;
        check("midrst_start", Start, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_prognum", ProgNum, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("idle_start", Start, 0);
            check("idle_busy", Busy, 0);
        end

        run_seq(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
